// File: rtl/calc_pkg.sv
// Purpose : shared types and 7-segment decode for the sequential calculator.
// Latency : n/a (types and a combinational helper only).
// Backpress: n/a; keys are edge events with no handshake.
package calc_pkg;

  // Operation selected by the key edges; priority is resolved in calc_seq.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; all ones means a dark digit.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Hex nibble to active-low segment pattern, dp kept off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/calc_seg_scan.sv
// Purpose : multiplexed hex display of the result, one digit every SCAN_DIV clocks.
// Latency : anodes/segments follow the scan register and result combinationally.
// Backpress: none; free-running scan.
// Ports: clk, rst_n (async active-low); value[WIDTH-1:0] in;
//        anodes[DIGITS-1:0] active-low digit select; segments[7:0] active-low {dp,g..a}.
// Build option: CALC_BLANK_EN blanks leading-zero digits (digit 0 always lit).
module calc_seg_scan
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  output logic [DIGITS-1:0] anodes,
  output logic [7:0]        segments
);

  localparam int NW = 4 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV + 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [NW-1:0] val_ext;
  logic [3:0]    nib;
  logic          blank;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    dig_d     = dig_q;
    if (div_cnt_q == CW'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      dig_d     = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      dig_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
    end
  end

  assign val_ext = NW'(value);
  assign nib     = val_ext[4*int'(dig_q) +: 4];

`ifdef CALC_BLANK_EN
  // msd = highest nonzero digit; everything above it is dark.
  logic [DW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (val_ext[4*i +: 4] != 4'h0) msd = DW'(i);
    end
    blank = (dig_q > msd);
  end
`else
  assign blank = 1'b0;
`endif

  assign anodes   = ~(DIGITS'(1) << dig_q);
  assign segments = blank ? SEG_BLANK : hex_to_seg(nib);

endmodule

// File: rtl/calc_seq.sv
// Purpose : key-driven calculator: loads A/B, runs add/sub (1 clk) or mul/div (WIDTH clks).
// Latency : result at T+1 for add/sub/div-by-zero, T+WIDTH+1 for mul/div (T = key edge cycle).
// Backpress: keys arriving while busy are dropped, never queued.
// Ports: clk, rst_n (async active-low); in_number[WIDTH-1:0]; k_1/k_2 load A/B;
//        p_key/m_key/um_key/del_key add/sub/mul/div; anodes, segments to the display;
//        led[0]=busy, led[1]=overflow/error, led[2]=result valid.
// Build option: CALC_BLANK_EN (display leading-zero blanking, see calc_seg_scan).
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_number,
  input  logic              k_1,
  input  logic              k_2,
  input  logic              p_key,
  input  logic              m_key,
  input  logic              um_key,
  input  logic              del_key,
  output logic [DIGITS-1:0] anodes,
  output logic [7:0]        segments,
  output logic [2:0]        led
);

  // Key vector bit order: {del, um, m, p, k_2, k_1}.
  logic [5:0] keys_raw, edges;
  logic [5:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, wb_q, wb_d;
  logic [2:0]         led_q, led_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, wa_q, wa_d;

  logic               busy, op_vld, last, qbit;
  op_e                op;
  logic [WIDTH:0]     sum, diff, shifted, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem_n;

  assign keys_raw = {del_key, um_key, m_key, p_key, k_2, k_1};
  assign edges    = sync2_q & ~prev_q;

  always_comb begin
    sync1_d = keys_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wa_d    = wa_q;
    wb_d    = wb_q;

    busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    last = (cnt_q == 5'(WIDTH - 1));

    op_vld = 1'b1;
    op     = OP_ADD;
    if (edges[2])      op = OP_ADD;
    else if (edges[3]) op = OP_SUB;
    else if (edges[4]) op = OP_MUL;
    else if (edges[5]) op = OP_DIV;
    else               op_vld = 1'b0;

    sum  = {1'b0, a_q} + {1'b0, b_q};
    diff = {1'b0, a_q} - {1'b0, b_q};

    // Shift-add step: wa holds the shifted multiplicand, wb the remaining multiplier bits.
    prod = acc_q + (wb_q[0] ? wa_q : '0);

    // Restoring divide step: acc low half is the partial remainder, wa low half
    // shifts the dividend out the top while quotient bits enter at the bottom.
    // trial[WIDTH] is set exactly when the subtraction borrows.
    shifted = {acc_q[WIDTH-1:0], wa_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    qbit    = ~trial[WIDTH];
    rem_n   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

    if (!busy) begin
      if (edges[0]) begin
        a_d      = in_number;
        led_d[2] = 1'b0;
      end
      if (edges[1]) begin
        b_d      = in_number;
        led_d[2] = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (op_vld) begin
          case (op)
            OP_ADD: begin
              res_d   = sum[WIDTH-1:0];
              led_d   = {1'b1, sum[WIDTH], 1'b0};
              state_d = ST_DONE;
            end
            OP_SUB: begin
              res_d   = diff[WIDTH-1:0];
              led_d   = {1'b1, diff[WIDTH], 1'b0};
              state_d = ST_DONE;
            end
            OP_MUL: begin
              wa_d     = {{WIDTH{1'b0}}, a_q};
              wb_d     = b_q;
              acc_d    = '0;
              cnt_d    = '0;
              led_d[0] = 1'b1;
              state_d  = ST_MUL;
            end
            default: begin
              if (b_q == '0) begin
                res_d   = '1;
                led_d   = 3'b110;
                state_d = ST_DONE;
              end else begin
                wa_d     = {{WIDTH{1'b0}}, a_q};
                acc_d    = '0;
                cnt_d    = '0;
                led_d[0] = 1'b1;
                state_d  = ST_DIV;
              end
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d = prod;
        wa_d  = wa_q << 1;
        wb_d  = wb_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          res_d   = prod[WIDTH-1:0];
          led_d   = {1'b1, |prod[2*WIDTH-1:WIDTH], 1'b0};
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = {{WIDTH{1'b0}}, rem_n};
        wa_d  = {wa_q[2*WIDTH-2:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          res_d   = {wa_q[WIDTH-2:0], qbit};
          led_d   = 3'b100;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

  assign led = led_q;

  calc_seg_scan #(
    .WIDTH   (WIDTH),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (res_q),
    .anodes  (anodes),
    .segments(segments)
  );

endmodule
